// File: rtl/wb_stage_if.sv
// ============================================================================
//  Module      : wb_stage_if
//  Description : Bundles the MEM->WB capture inputs, the WB control strobes,
//                the ID-stage operand read path and the register-file write
//                port that connect around wb_stage.
//                master : the surrounding pipeline (drives MEM/ID inputs)
//                slave  : wb_stage itself
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_stage_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);

    // MEM stage result being offered to WB
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_rd;
    logic                mem_wen;
    logic [2:0]          mem_ppp;
    logic                mem_is_load;
    logic [DATA_W-1:0]   mem_alu_data;
    logic [DATA_W-1:0]   mem_load_data;

    // WB pipeline control
    logic                wb_stall;
    logic                wb_flush;

    // ID-stage operand read path
    logic [ADDR_W-1:0]   id_rs1;
    logic [ADDR_W-1:0]   id_rs2;
    logic [DATA_W-1:0]   rf_rs1_data;
    logic [DATA_W-1:0]   rf_rs2_data;

    // Register-file write port
    logic [ADDR_W-1:0]   Wreg;
    logic [DATA_W-1:0]   Wdata;
    logic                Wreg_en;
    logic [2:0]          ppp;

    // Bypassed operands back to ID
    logic [DATA_W-1:0]   fwd_rs1_data;
    logic [DATA_W-1:0]   fwd_rs2_data;
    logic                fwd_rs1_hit;
    logic                fwd_rs2_hit;

    // Pipeline side: drives MEM/ID inputs, observes the write port and bypass
    modport master (
        output mem_valid, mem_rd, mem_wen, mem_ppp, mem_is_load,
               mem_alu_data, mem_load_data,
        output wb_stall, wb_flush,
        output id_rs1, id_rs2, rf_rs1_data, rf_rs2_data,
        input  Wreg, Wdata, Wreg_en, ppp,
        input  fwd_rs1_data, fwd_rs2_data, fwd_rs1_hit, fwd_rs2_hit
    );

    // Writeback stage side
    modport slave (
        input  mem_valid, mem_rd, mem_wen, mem_ppp, mem_is_load,
               mem_alu_data, mem_load_data,
        input  wb_stall, wb_flush,
        input  id_rs1, id_rs2, rf_rs1_data, rf_rs2_data,
        output Wreg, Wdata, Wreg_en, ppp,
        output fwd_rs1_data, fwd_rs2_data, fwd_rs1_hit, fwd_rs2_hit
    );

endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register and register-file writeback driver.
//                Selects load or ALU data, drives the register-file write
//                port (Wreg/Wdata/Wreg_en/ppp) and bypasses the in-flight WB
//                result, merged per ppp lane, to the ID-stage operands.
//                Optional feature macro: WB_RETIRE_CNT_EN adds a free-running
//                retire counter output (retire_cnt) counting WB writes.
//                Bit numbering of the datapath is big-endian: bit 0 is the
//                MSB, so "bits 0:31" is the upper word [63:32].
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int DATA_W = 64,   // fixed at 64: ppp lane map assumes it
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_stage_if.slave        bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    // ppp lane encodings
    localparam logic [2:0] c_PPP_ALL  = 3'b000;
    localparam logic [2:0] c_PPP_HI   = 3'b001;
    localparam logic [2:0] c_PPP_LO   = 3'b010;
    localparam logic [2:0] c_PPP_EVEN = 3'b011;
    localparam logic [2:0] c_PPP_ODD  = 3'b100;

    // Lane masks in [63:0] terms (big-endian byte 0 lives in [63:56])
    localparam logic [63:0] c_MASK_HI   = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] c_MASK_LO   = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] c_MASK_EVEN = 64'hFF00_FF00_FF00_FF00;
    localparam logic [63:0] c_MASK_ODD  = 64'h00FF_00FF_00FF_00FF;

    // ------------------------------------------------------------------
    // WB pipeline register fields
    // ------------------------------------------------------------------
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_rd_q,    wb_rd_d;
    logic                wb_wen_q,   wb_wen_d;
    logic [2:0]          wb_ppp_q,   wb_ppp_d;
    logic [DATA_W-1:0]   wb_data_q,  wb_data_d;

    logic                w_wreg_en;
    logic [DATA_W-1:0]   w_mask;

    logic                w_hit1, w_hit2;
    logic [DATA_W-1:0]   w_fwd1, w_fwd2;

    // Lane-merge of the WB value over a register-file read value
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] rf_val,
        input logic [DATA_W-1:0] mask
    );
        lane_merge = (wb_val & mask) | (rf_val & ~mask);
    endfunction

    // Next WB contents: flush beats stall, stall holds, otherwise capture MEM
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_wen_d   = wb_wen_q;
        wb_ppp_d   = wb_ppp_q;
        wb_data_d  = wb_data_q;
        if (bus.wb_flush) begin
            // Only validity matters for a flushed slot; other fields hold.
            wb_valid_d = 1'b0;
        end else if (!bus.wb_stall) begin
            wb_valid_d = bus.mem_valid;
            wb_rd_d    = bus.mem_rd;
            wb_wen_d   = bus.mem_wen;
            wb_ppp_d   = bus.mem_ppp;
            wb_data_d  = bus.mem_is_load ? bus.mem_load_data : bus.mem_alu_data;
        end
    end

    // WB pipeline register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_wen_q   <= 1'b0;
            wb_ppp_q   <= c_PPP_ALL;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            wb_ppp_q   <= wb_ppp_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Write enable: a stalled entry waits and writes in the cycle the stall
    // drops; r0 is never written.
    always_comb begin
        w_wreg_en = wb_valid_q & wb_wen_q & (wb_rd_q != '0) & ~bus.wb_stall;
    end

    // Lane mask decode; reserved encodings behave like full width
    always_comb begin
        unique case (wb_ppp_q)
            c_PPP_HI:   w_mask = c_MASK_HI;
            c_PPP_LO:   w_mask = c_MASK_LO;
            c_PPP_EVEN: w_mask = c_MASK_EVEN;
            c_PPP_ODD:  w_mask = c_MASK_ODD;
            default:    w_mask = {DATA_W{1'b1}};
        endcase
    end

    // rs1 bypass: register file writes on the edge but reads combinationally,
    // so the value being written this cycle must be merged in here.
    always_comb begin
        w_hit1 = 1'b0;
        w_fwd1 = bus.rf_rs1_data;
        if (bus.id_rs1 == '0) begin
            w_fwd1 = '0;
        end else if (w_wreg_en && (bus.id_rs1 == wb_rd_q)) begin
            w_hit1 = 1'b1;
            w_fwd1 = lane_merge(wb_data_q, bus.rf_rs1_data, w_mask);
        end
    end

    // rs2 bypass, same rules as rs1
    always_comb begin
        w_hit2 = 1'b0;
        w_fwd2 = bus.rf_rs2_data;
        if (bus.id_rs2 == '0) begin
            w_fwd2 = '0;
        end else if (w_wreg_en && (bus.id_rs2 == wb_rd_q)) begin
            w_hit2 = 1'b1;
            w_fwd2 = lane_merge(wb_data_q, bus.rf_rs2_data, w_mask);
        end
    end

    // Register-file write port and bypass outputs
    assign bus.Wreg         = wb_rd_q;
    assign bus.Wdata        = wb_data_q;
    assign bus.ppp          = wb_ppp_q;
    assign bus.Wreg_en      = w_wreg_en;
    assign bus.fwd_rs1_data = w_fwd1;
    assign bus.fwd_rs2_data = w_fwd2;
    assign bus.fwd_rs1_hit  = w_hit1;
    assign bus.fwd_rs2_hit  = w_hit2;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Retire count advances once per committed write and wraps naturally
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (w_wreg_en) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // Retire counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    // Counter width is only meaningful with the retire counter present
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage. Expected register-file
//                writes are queued when an instruction is issued and popped
//                when the write port fires; direct checks cover reset,
//                bypass lane merging, stall/flush and r0 handling.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic [2:0]        ppp;
    } wr_t;

    logic clk;
    logic rst;

    wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
`endif

    wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_writes = 0;
    wr_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [ADDR_W-1:0] rd, input logic wen,
                             input logic [2:0] p, input logic ld,
                             input logic [63:0] alu, input logic [63:0] ldd);
        bus.mem_valid     = v;
        bus.mem_rd        = rd;
        bus.mem_wen       = wen;
        bus.mem_ppp       = p;
        bus.mem_is_load   = ld;
        bus.mem_alu_data  = alu;
        bus.mem_load_data = ldd;
    endtask

    // Present one instruction for one edge, queue its write if one is expected
    task automatic issue(input logic [ADDR_W-1:0] rd, input logic wen, input logic [2:0] p,
                         input logic ld, input logic [63:0] alu, input logic [63:0] ldd,
                         input logic expect_write);
        wr_t e;
        drive_mem(1'b1, rd, wen, p, ld, alu, ldd);
        if (expect_write) begin
            e.rd   = rd;
            e.data = ld ? ldd : alu;
            e.ppp  = p;
            sb_q.push_back(e);
        end
        tick();
        drive_mem(1'b0, '0, 1'b0, 3'b000, 1'b0, 64'h0, 64'h0);
    endtask

    // Scoreboard: every write-port firing must match the oldest queued write
    always @(negedge clk) begin
        wr_t e;
        if (bus.Wreg_en === 1'b1) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", {59'd0, bus.Wreg}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_wreg",  {59'd0, bus.Wreg}, {59'd0, e.rd});
                check("sb_wdata", bus.Wdata, e.data);
                check("sb_ppp",   {61'd0, bus.ppp}, {61'd0, e.ppp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [2:0]  p_tab [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110};
    logic [63:0] m_tab [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                               64'hFF00_FF00_FF00_FF00, 64'h00FF_00FF_00FF_00FF,
                               64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] rf_pat = 64'h0123_4567_89AB_CDEF;

    initial begin
        rst = 1'b1;
        drive_mem(1'b0, '0, 1'b0, 3'b000, 1'b0, 64'h0, 64'h0);
        bus.wb_stall    = 1'b0;
        bus.wb_flush    = 1'b0;
        bus.id_rs1      = 5'd3;
        bus.id_rs2      = 5'd0;
        bus.rf_rs1_data = 64'h77;
        bus.rf_rs2_data = 64'h99;
        #1;
        // Reset state
        check("rst_wreg",    {59'd0, bus.Wreg}, 64'd0);
        check("rst_wdata",   bus.Wdata, 64'd0);
        check("rst_ppp",     {61'd0, bus.ppp}, 64'd0);
        check("rst_wreg_en", {63'd0, bus.Wreg_en}, 64'd0);
        check("rst_hit1",    {63'd0, bus.fwd_rs1_hit}, 64'd0);
        check("rst_hit2",    {63'd0, bus.fwd_rs2_hit}, 64'd0);
        check("rst_fwd1",    bus.fwd_rs1_data, 64'h77);
        check("rst_fwd2_r0", bus.fwd_rs2_data, 64'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic ALU writeback, one-cycle latency
        issue(5'd3, 1'b1, 3'b000, 1'b0, 64'h1111_2222_3333_4444, 64'h0, 1'b1);
        check("alu_wreg",    {59'd0, bus.Wreg}, 64'd3);
        check("alu_wreg_en", {63'd0, bus.Wreg_en}, 64'd1);
        check("alu_wdata",   bus.Wdata, 64'h1111_2222_3333_4444);
        bus.id_rs1 = 5'd3; bus.rf_rs1_data = 64'h0;
        #1;
        check("alu_hit1", {63'd0, bus.fwd_rs1_hit}, 64'd1);
        check("alu_fwd1", bus.fwd_rs1_data, 64'h1111_2222_3333_4444);
        tick();
        check("bubble_wreg_en", {63'd0, bus.Wreg_en}, 64'd0);

        // Upper-word lane merge on both operands; non-matching rs misses
        issue(5'd5, 1'b1, 3'b001, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b1);
        bus.id_rs1 = 5'd5; bus.rf_rs1_data = 64'h5555_5555_5555_5555;
        bus.id_rs2 = 5'd5; bus.rf_rs2_data = 64'h0;
        #1;
        check("hi_hit1", {63'd0, bus.fwd_rs1_hit}, 64'd1);
        check("hi_fwd1", bus.fwd_rs1_data, 64'hAAAA_AAAA_5555_5555);
        check("hi_fwd2", bus.fwd_rs2_data, 64'hAAAA_AAAA_0000_0000);
        bus.id_rs2 = 5'd6; bus.rf_rs2_data = 64'h1234;
        #1;
        check("miss_hit2", {63'd0, bus.fwd_rs2_hit}, 64'd0);
        check("miss_fwd2", bus.fwd_rs2_data, 64'h1234);

        // Remaining lane encodings, including a reserved one
        for (int i = 0; i < 5; i++) begin
            issue(5'd5, 1'b1, p_tab[i], 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
            bus.id_rs1 = 5'd5; bus.rf_rs1_data = 64'h0;
            bus.id_rs2 = 5'd5; bus.rf_rs2_data = rf_pat;
            #1;
            check($sformatf("lane%0d_fwd1", i), bus.fwd_rs1_data, m_tab[i]);
            check($sformatf("lane%0d_fwd2", i), bus.fwd_rs2_data, m_tab[i] | rf_pat);
        end
        tick();

        // Load held by a 3-cycle stall writes exactly once afterwards
        issue(5'd7, 1'b1, 3'b000, 1'b1, 64'hBAD0, 64'hDEAD, 1'b1);
        bus.wb_stall = 1'b1;
        bus.id_rs1 = 5'd7; bus.rf_rs1_data = 64'h42;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_wreg_en", c), {63'd0, bus.Wreg_en}, 64'd0);
            check($sformatf("stall%0d_hit1", c), {63'd0, bus.fwd_rs1_hit}, 64'd0);
            check($sformatf("stall%0d_wdata", c), bus.Wdata, 64'hDEAD);
            if (c < 2) tick();
        end
        tick();
        bus.wb_stall = 1'b0;
        #1;
        check("unstall_wreg_en", {63'd0, bus.Wreg_en}, 64'd1);
        check("unstall_wdata",   bus.Wdata, 64'hDEAD);
        tick();
        check("post_stall_wreg_en", {63'd0, bus.Wreg_en}, 64'd0);

        // Flush wins over stall: the held entry must never write
        issue(5'd10, 1'b1, 3'b000, 1'b0, 64'hF1F1, 64'h0, 1'b0);
        bus.wb_stall = 1'b1;
        bus.wb_flush = 1'b1;
        tick();
        bus.wb_stall = 1'b0;
        bus.wb_flush = 1'b0;
        bus.id_rs1 = 5'd10; bus.rf_rs1_data = 64'h33;
        #1;
        check("flush_wreg_en", {63'd0, bus.Wreg_en}, 64'd0);
        check("flush_hit1",    {63'd0, bus.fwd_rs1_hit}, 64'd0);
        check("flush_fwd1",    bus.fwd_rs1_data, 64'h33);
        tick();

        // Destination r0 never writes, and r0 reads are forced to zero
        issue(5'd0, 1'b1, 3'b000, 1'b0, 64'hCAFE, 64'h0, 1'b0);
        bus.id_rs1 = 5'd0; bus.rf_rs1_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("r0_wreg_en", {63'd0, bus.Wreg_en}, 64'd0);
        check("r0_hit1",    {63'd0, bus.fwd_rs1_hit}, 64'd0);
        check("r0_fwd1",    bus.fwd_rs1_data, 64'h0);
        tick();

`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", {32'd0, retire_cnt}, 64'(n_writes));
`endif

        // Asynchronous reset with a write pending clears outputs at once
        issue(5'd12, 1'b1, 3'b000, 1'b0, 64'h1234_5678, 64'h0, 1'b0);
        check("pre_rst_wreg_en", {63'd0, bus.Wreg_en}, 64'd1);
        rst = 1'b1;
        #1;
        check("arst_wreg_en", {63'd0, bus.Wreg_en}, 64'd0);
        check("arst_wdata",   bus.Wdata, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
